// File: rtl/alu_ctrl_pkg.sv
// Shared opcode and phase encodings for the accumulator datapath controller.
// The opcode values are shared with the alu.
package alu_ctrl_pkg;

   localparam int unsigned OPCODE_W = 3;
   localparam int unsigned PHASE_W  = 3;

   localparam logic [OPCODE_W-1:0] HLT = 3'd0;
   localparam logic [OPCODE_W-1:0] SKZ = 3'd1;
   localparam logic [OPCODE_W-1:0] ADD = 3'd2;
   localparam logic [OPCODE_W-1:0] AND = 3'd3;
   localparam logic [OPCODE_W-1:0] XOR = 3'd4;
   localparam logic [OPCODE_W-1:0] LDA = 3'd5;
   localparam logic [OPCODE_W-1:0] STO = 3'd6;
   localparam logic [OPCODE_W-1:0] JMP = 3'd7;

   localparam logic [PHASE_W-1:0] INST_ADDR  = 3'd0;
   localparam logic [PHASE_W-1:0] INST_FETCH = 3'd1;
   localparam logic [PHASE_W-1:0] INST_LOAD  = 3'd2;
   localparam logic [PHASE_W-1:0] IDLE       = 3'd3;
   localparam logic [PHASE_W-1:0] OP_ADDR    = 3'd4;
   localparam logic [PHASE_W-1:0] OP_FETCH   = 3'd5;
   localparam logic [PHASE_W-1:0] ALU_OP     = 3'd6;
   localparam logic [PHASE_W-1:0] STORE      = 3'd7;

   // Instructions that read a memory operand and write the accumulator.
   function automatic logic aluop(input logic [OPCODE_W-1:0] op);
      return (op == ADD) || (op == AND) || (op == XOR) || (op == LDA);
   endfunction

endpackage

// File: rtl/phase_counter.sv
// 3-bit wrapping phase counter with enable and synchronous active-low clear.
module phase_counter
   import alu_ctrl_pkg::*;
(
   input  logic               clk,
   input  logic               clr_,
   input  logic               en,
   output logic [PHASE_W-1:0] count
);

   logic [PHASE_W-1:0] count_q, count_d;

   always_comb begin
      count_d = count_q;
      if (en) count_d = count_q + 3'd1;
   end

   always_ff @(posedge clk) begin
      if (!clr_) count_q <= INST_ADDR;
      else       count_q <= count_d;
   end

   assign count = count_q;

endmodule

// File: rtl/alu_controller.sv
// Phase sequencer for the 8-bit accumulator datapath: steps the 8-phase
// instruction cycle, issues datapath strobes, and handles halt/go and memory stalls.
module alu_controller
   import alu_ctrl_pkg::*;
#(
   parameter int unsigned OPCODE_W = 3
) (
   input  logic                clk,
   input  logic                rst_,
   input  logic [OPCODE_W-1:0] opcode,
   input  logic                zero,
   input  logic                mem_ready,
   input  logic                go,
   output logic                sel,
   output logic                rd,
   output logic                ld_ir,
   output logic                inc_pc,
   output logic                ld_pc,
   output logic                ld_ac,
   output logic                wr,
   output logic                data_e,
   output logic                halt,
   output logic [2:0]          phase
);

   typedef enum logic {StRun, StHalted} run_state_e;

   run_state_e         state_q, state_d;
   logic [PHASE_W-1:0] phase_q;
   logic               is_aluop, is_hlt, is_skz, is_sto, is_jmp;

   assign is_aluop = aluop(opcode);
   assign is_hlt   = (opcode == HLT);
   assign is_skz   = (opcode == SKZ);
   assign is_sto   = (opcode == STO);
   assign is_jmp   = (opcode == JMP);

   // The phase still advances on the halting edge, so it freezes in OP_FETCH.
   phase_counter u_phase_counter (
      .clk   (clk),
      .clr_  (rst_),
      .en    (mem_ready && (state_q == StRun)),
      .count (phase_q)
   );

   always_ff @(posedge clk) begin
      if (!rst_) state_q <= StRun;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StRun: begin
            if (phase_q == OP_ADDR && is_hlt && mem_ready) state_d = StHalted;
         end
         StHalted: begin
            if (go) state_d = StRun;
         end
         default: state_d = StRun;
      endcase
   end

   always_comb begin
      sel    = 1'b0;
      rd     = 1'b0;
      ld_ir  = 1'b0;
      inc_pc = 1'b0;
      ld_pc  = 1'b0;
      ld_ac  = 1'b0;
      wr     = 1'b0;
      data_e = 1'b0;
      halt   = 1'b0;
      if (state_q == StHalted) begin
         halt = 1'b1;
      end else begin
         unique case (phase_q)
            INST_ADDR: sel = 1'b1;
            INST_FETCH: begin
               sel = 1'b1;
               rd  = 1'b1;
            end
            INST_LOAD: begin
               sel   = 1'b1;
               rd    = 1'b1;
               ld_ir = mem_ready;
            end
            IDLE: begin
               sel = 1'b1;
               rd  = 1'b1;
            end
            OP_ADDR: begin
               inc_pc = mem_ready;
               halt   = is_hlt;
            end
            OP_FETCH: rd = is_aluop;
            ALU_OP: begin
               rd     = is_aluop;
               inc_pc = is_skz && zero && mem_ready;
               ld_pc  = is_jmp && mem_ready;
               data_e = is_sto;
            end
            STORE: begin
               rd     = is_aluop;
               ld_ac  = is_aluop && mem_ready;
               ld_pc  = is_jmp && mem_ready;
               wr     = is_sto && mem_ready;
               data_e = is_sto;
            end
            default: ;
         endcase
      end
   end

   assign phase = phase_q;

endmodule

// File: tb/tb_alu_controller.sv
// Self-checking bench for alu_controller: directed test-plan scenarios with literal
// expectations, then randomized stimulus checked every cycle against a behavioural model.
module tb_alu_controller;

   logic       clk = 1'b0;
   logic       rst_;
   logic [2:0] opcode;
   logic       zero, mem_ready, go;
   logic       sel, rd, ld_ir, inc_pc, ld_pc, ld_ac, wr, data_e, halt;
   logic [2:0] phase;

   int n_vec  = 0;
   int n_fail = 0;

   // Model state
   int m_phase     = 0;
   bit m_halted    = 1'b0;
   bit model_valid = 1'b0;

   logic [11:0] dut_vec;
   assign dut_vec = {sel, rd, ld_ir, inc_pc, ld_pc, ld_ac, wr, data_e, halt, phase};

   alu_controller #(.OPCODE_W(3)) dut (
      .clk       (clk),
      .rst_      (rst_),
      .opcode    (opcode),
      .zero      (zero),
      .mem_ready (mem_ready),
      .go        (go),
      .sel       (sel),
      .rd        (rd),
      .ld_ir     (ld_ir),
      .inc_pc    (inc_pc),
      .ld_pc     (ld_pc),
      .ld_ac     (ld_ac),
      .wr        (wr),
      .data_e    (data_e),
      .halt      (halt),
      .phase     (phase)
   );

   always #5 clk = ~clk;

   // Expected outputs straight from the phase table, as boolean rules.
   function automatic logic [11:0] model_out(input int p, input bit h, input logic [2:0] op,
                                             input logic z, input logic mr);
      bit alu_op, e_sel, e_rd, e_ldir, e_inc, e_ldpc, e_ldac, e_wr, e_de, e_halt;
      logic [2:0] ph;
      ph = 3'(p);
      if (h) return {9'b0_0000_0001, ph};
      alu_op = (op == 3'd2) || (op == 3'd3) || (op == 3'd4) || (op == 3'd5);
      e_sel  = (p <= 3);
      e_rd   = (p >= 1 && p <= 3) || (p >= 5 && alu_op);
      e_ldir = mr && (p == 2);
      e_inc  = mr && ((p == 4) || (p == 6 && op == 3'd1 && z));
      e_ldpc = mr && (op == 3'd7) && (p == 6 || p == 7);
      e_ldac = mr && alu_op && (p == 7);
      e_wr   = mr && (op == 3'd6) && (p == 7);
      e_de   = (op == 3'd6) && (p == 6 || p == 7);
      e_halt = (p == 4) && (op == 3'd0);
      return {e_sel, e_rd, e_ldir, e_inc, e_ldpc, e_ldac, e_wr, e_de, e_halt, ph};
   endfunction

   always @(posedge clk) begin
      if (!rst_) begin
         m_phase     = 0;
         m_halted    = 1'b0;
         model_valid = 1'b1;
      end else if (m_halted) begin
         if (go) m_halted = 1'b0;
      end else if (mem_ready) begin
         if (m_phase == 4 && opcode == 3'd0) m_halted = 1'b1;
         m_phase = (m_phase + 1) % 8;
      end
   end

   always @(negedge clk) begin
      logic [11:0] exp_vec;
      if (model_valid) begin
         exp_vec = model_out(m_phase, m_halted, opcode, zero, mem_ready);
         n_vec++;
         if (dut_vec !== exp_vec) begin
            n_fail++;
            $display("FAIL model t=%0t got=%03h want=%03h (sel rd ld_ir inc_pc ld_pc ld_ac wr data_e halt phase)",
                     $time, dut_vec, exp_vec);
         end
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [11:0] want);
      #1;
      n_vec++;
      if (dut_vec !== want) begin
         n_fail++;
         $display("FAIL %s got=%03h want=%03h", name, dut_vec, want);
      end
   endtask

   task automatic goto_phase(input int p);
      int n = 0;
      while (m_phase != p && n < 20) begin
         cyc();
         n++;
      end
      n_vec++;
      if (m_phase != p) begin
         n_fail++;
         $display("FAIL goto_phase got=%0d want=%0d", m_phase, p);
      end
   endtask

   initial begin
      rst_ = 1'b0; opcode = 3'd2; zero = 1'b0; mem_ready = 1'b1; go = 1'b0;
      cyc(); cyc();
      rst_ = 1'b1;
      chk("reset", 12'h800);
      cyc(); cyc();
      chk("add_ld_ir", 12'hE02);
      cyc(); cyc();
      chk("add_inc_pc", 12'h104);
      cyc(); cyc(); cyc();
      chk("add_ld_ac", 12'h447);
      cyc();
      chk("wrap", 12'h800);

      opcode = 3'd0;
      goto_phase(4);
      chk("hlt_op_addr", 12'h10C);
      cyc();
      chk("halted", 12'h00D);
      for (int i = 0; i < 10; i++) begin
         mem_ready = 1'($urandom_range(0, 1));
         cyc();
      end
      mem_ready = 1'b1;
      chk("halted_hold", 12'h00D);
      go = 1'b1;
      cyc();
      go = 1'b0;
      chk("go_resume", 12'h005);
      goto_phase(0);

      opcode = 3'd6;
      goto_phase(6);
      chk("sto_alu_op", 12'h016);
      cyc();
      chk("sto_store", 12'h037);

      opcode = 3'd2;
      goto_phase(2);
      mem_ready = 1'b0;
      chk("stall_0", 12'hC02);
      cyc();
      chk("stall_1", 12'hC02);
      cyc();
      chk("stall_2", 12'hC02);
      cyc();
      mem_ready = 1'b1;
      chk("stall_release", 12'hE02);

      opcode = 3'd1; zero = 1'b1;
      goto_phase(6);
      chk("skz_zero", 12'h106);
      zero = 1'b0;
      chk("skz_nonzero", 12'h006);

      opcode = 3'd7;
      goto_phase(5);
      cyc();
      chk("jmp_alu_op", 12'h086);
      cyc();
      chk("jmp_store", 12'h087);

      opcode = 3'd0;
      goto_phase(5);
      chk("halt_again", 12'h00D);
      rst_ = 1'b0; go = 1'b1;
      cyc();
      rst_ = 1'b1; go = 1'b0;
      chk("reset_while_halted", 12'h800);

      for (int i = 0; i < 3000; i++) begin
         rst_      = ($urandom_range(0, 59) != 0);
         opcode    = 3'($urandom_range(0, 7));
         zero      = 1'($urandom_range(0, 1));
         mem_ready = ($urandom_range(0, 3) != 0);
         go        = ($urandom_range(0, 5) == 0);
         cyc();
      end

      @(negedge clk);
      #1;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
